// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
module data_cache #(
   parameter int WIDTH = 32,
   parameter int SETS  = 8,
   parameter int WORDS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_re,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             cpu_stall,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ready,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam int OB = $clog2(WORDS);
   localparam int IB = $clog2(SETS);
   localparam int TB = WIDTH - 2 - OB - IB;
   localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

   state_t           state_q;
   logic [SETS-1:0]  valid_q;
   logic [TB-1:0]    tag_q  [SETS];
   logic [WIDTH-1:0] data_q [SETS][WORDS];
   logic [OB-1:0]    beat_q;
   logic             done_q;
   logic             hit_q;
   logic             mem_req_q;
   logic             mem_we_q;
   logic [WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] mem_wdata_q;

   // CPU-side address split; the byte-lane bits are unused
   logic [OB-1:0] cpu_off;
   logic [IB-1:0] cpu_idx;
   logic [TB-1:0] cpu_tag;
   logic          unused_byte_bits;
   assign cpu_off          = cpu_addr[OB+1:2];
   assign cpu_idx          = cpu_addr[IB+OB+1:OB+2];
   assign cpu_tag          = cpu_addr[WIDTH-1:IB+OB+2];
   assign unused_byte_bits = ^cpu_addr[1:0];

   // The outstanding memory address doubles as the latched line/word address
   logic [OB-1:0] mem_off;
   logic [IB-1:0] mem_idx;
   logic [TB-1:0] mem_tag;
   assign mem_off = mem_addr_q[OB+1:2];
   assign mem_idx = mem_addr_q[IB+OB+1:OB+2];
   assign mem_tag = mem_addr_q[WIDTH-1:IB+OB+2];

   logic hit;
   logic store_req;
   logic load_req;
   assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   // done_q hides the still-held store for the cycle after it completes
   assign store_req = cpu_we && !done_q;
   assign load_req  = cpu_re && !cpu_we && !done_q;

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Same-cycle hit data and stall request towards the pipeline
   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (store_req) begin
                  cpu_stall = 1'b1;
               end else if (load_req) begin
                  if (hit) cpu_rdata = data_q[cpu_idx][cpu_off];
                  else     cpu_stall = 1'b1;
               end
            end
            default: cpu_stall = 1'b1;
         endcase
      end
   end

   // Controller FSM: valid bits, beat counter and registered memory-port outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         beat_q      <= '0;
         done_q      <= 1'b0;
         hit_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (store_req) begin
                  state_q     <= WRITE;
                  hit_q       <= hit;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {cpu_addr[WIDTH-1:2], 2'b00};
                  mem_wdata_q <= cpu_wdata;
               end else if (load_req && !hit) begin
                  state_q          <= REFILL;
                  beat_q           <= '0;
                  valid_q[cpu_idx] <= 1'b0;
                  mem_req_q        <= 1'b1;
                  mem_we_q         <= 1'b0;
                  mem_addr_q       <= {cpu_tag, cpu_idx, {OB{1'b0}}, 2'b00};
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == LAST_BEAT) begin
                     state_q          <= IDLE;
                     valid_q[mem_idx] <= 1'b1;
                     mem_req_q        <= 1'b0;
                     mem_addr_q       <= '0;
                  end else begin
                     mem_addr_q <= {mem_tag, mem_idx, beat_q + 1'b1, 2'b00};
                  end
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  state_q     <= IDLE;
                  done_q      <= 1'b1;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Line storage: refill beats, tag on the last beat, write-through hit update
   always_ff @(posedge clk) begin
      if (state_q == REFILL && mem_ready) begin
         data_q[mem_idx][beat_q] <= mem_rdata;
         if (beat_q == LAST_BEAT) tag_q[mem_idx] <= mem_tag;
      end else if (state_q == WRITE && mem_ready && hit_q) begin
         data_q[mem_idx][mem_off] <= mem_wdata_q;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - scoreboard bench for data_cache against a line-map reference model
module tb_data_cache;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_re = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   data_cache #(.WIDTH(32), .SETS(8), .WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          we;
      logic [31:0] data;
   } beat_t;

   int checks = 0;
   int failures = 0;
   int mode = 0;          // 0: ready every cycle, 1: two wait cycles per beat, 2: random
   bit mon_en = 1'b0;

   beat_t       beat_q[$];
   logic [31:0] rdata_q[$];

   logic [31:0] bmem    [logic [31:0]];   // what the backing memory holds
   logic [31:0] ref_mem [logic [31:0]];   // what the CPU should observe
   bit   [7:0]  mv = '0;                  // model: line present per index
   logic [24:0] mt [8];                   // model: tag per index

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] bmem_rd(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return dflt(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return dflt(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Backing-memory responder
   initial begin : responder
      int  wcnt;
      bit  rdy;
      wcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = (wcnt == 2);
               default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            if (rdy) wcnt = 0;
            else     wcnt++;
            mem_ready = rdy;
            mem_rdata = (rdy && !mem_we) ? bmem_rd(mem_addr) : $urandom;
            if (rdy && mem_we) bmem[mem_addr] = mem_wdata;
         end else begin
            wcnt = 0;
            mem_ready = (mode == 2) && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a beat or load data
   initial begin : monitor
      beat_t b;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            if (mem_req && mem_ready) begin
               if (beat_q.size() == 0) begin
                  chk("unexpected_beat", mem_addr, 32'hFFFF_FFFF);
               end else begin
                  b = beat_q.pop_front();
                  chk("beat_addr", mem_addr, b.addr);
                  chk("beat_we", {31'b0, mem_we}, {31'b0, b.we});
                  if (b.we) chk("beat_wdata", mem_wdata, b.data);
               end
            end
            if (cpu_re && !cpu_we && !cpu_stall) begin
               if (rdata_q.size() == 0) chk("unexpected_load", cpu_rdata, 32'hFFFF_FFFF);
               else                     chk("load_data", cpu_rdata, rdata_q.pop_front());
            end
         end
      end
   end

   function automatic int fill_cost();
      return (mode == 1) ? 1 + 3 * 4 : 1 + 4;
   endfunction

   function automatic int write_cost();
      return (mode == 1) ? 1 + 3 : 2;
   endfunction

   task automatic do_op(input bit we, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] wa;
      logic [2:0]  idx;
      logic [24:0] tg;
      bit          miss;
      int          stalls;
      int          exp_stalls;
      beat_t       b;
      wa  = {a[31:2], 2'b00};
      idx = wa[6:4];
      tg  = wa[31:7];
      miss = 1'b0;
      if (!we) begin
         miss = !(mv[idx] && mt[idx] == tg);
         rdata_q.push_back(ref_rd(wa));
         if (miss) begin
            for (int k = 0; k < 4; k++) begin
               b.addr = {wa[31:4], 4'b0000} + 32'(4 * k);
               b.we   = 1'b0;
               b.data = '0;
               beat_q.push_back(b);
            end
         end
         mv[idx] = 1'b1;
         mt[idx] = tg;
         exp_stalls = miss ? fill_cost() : 0;
      end else begin
         b.addr = wa;
         b.we   = 1'b1;
         b.data = d;
         beat_q.push_back(b);
         ref_mem[wa] = d;
         exp_stalls = write_cost();
      end
      @(posedge clk);
      #1;
      cpu_we    = we;
      cpu_re    = we ? ($urandom_range(0, 1) == 1) : 1'b1;
      cpu_addr  = wa | 32'($urandom_range(0, 3));
      cpu_wdata = d;
      stalls = 0;
      forever begin
         @(negedge clk);
         if (!cpu_stall) break;
         stalls++;
         if (stalls > 200) begin
            chk("stall_timeout", 32'(stalls), 32'(exp_stalls));
            break;
         end
      end
      if (mode != 2) chk(we ? "store_stall_cycles" : "load_stall_cycles", 32'(stalls), 32'(exp_stalls));
      if (!we && !miss) chk("hit_no_mem_req", {31'b0, mem_req}, 32'd0);
      @(posedge clk);
      #1;
      cpu_re = 1'b0;
      cpu_we = 1'b0;
   endtask

   initial begin : stimulus
      int n;
      for (int i = 0; i < 4; i++) begin
         bmem[32'h100 + 32'(4 * i)]    = 32'hA0 + 32'(i);
         ref_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
      end

      // Reset state, with a load held so the gating of stall is exercised
      cpu_re   = 1'b1;
      cpu_addr = 32'h100;
      #3;
      chk("reset_outputs", 32'(|{cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata}), 32'd0);
      cpu_re = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", 32'(|{cpu_stall, mem_req, cpu_rdata}), 32'd0);
      mon_en = 1'b1;

      // Directed scenarios, memory always ready
      mode = 0;
      do_op(1'b0, 32'h100, '0);
      do_op(1'b0, 32'h108, '0);
      do_op(1'b1, 32'h104, 32'hDEAD_BEEF);
      do_op(1'b0, 32'h104, '0);
      do_op(1'b1, 32'h900, 32'h1234_5678);
      do_op(1'b0, 32'h900, '0);

      // Conflict eviction with two wait cycles per beat
      mode = 1;
      do_op(1'b0, 32'h180, '0);
      do_op(1'b0, 32'h100, '0);
      do_op(1'b1, 32'h188, 32'h0BAD_F00D);
      do_op(1'b0, 32'h188, '0);

      // Reset in the middle of a refill, then the same load again
      mode = 0;
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      cpu_re   = 1'b1;
      cpu_addr = 32'h200;
      n = 0;
      for (int c = 0; c < 50 && n < 2; c++) begin
         @(negedge clk);
         if (mem_req && mem_ready) n++;
      end
      chk("abort_beats_seen", 32'(n), 32'd2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_reset_outputs", 32'(|{cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata}), 32'd0);
      mv = '0;
      @(negedge clk);
      rst    = 1'b0;
      cpu_re = 1'b0;
      mon_en = 1'b1;
      do_op(1'b0, 32'h200, '0);
      do_op(1'b0, 32'h20C, '0);

      // Randomized traffic over a small address window for hits and conflicts
      mode = 2;
      for (int i = 0; i < 150; i++) begin
         do_op($urandom_range(0, 2) == 0, 32'($urandom_range(0, 1023)), $urandom);
      end
      mode = 0;
      for (int i = 0; i < 30; i++) begin
         do_op($urandom_range(0, 3) == 0, 32'($urandom_range(0, 1023)), $urandom);
      end

      repeat (3) @(negedge clk);
      chk("beats_left", 32'(beat_q.size()), 32'd0);
      chk("loads_left", 32'(rdata_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter SETS, default 8: number of lines (power of two).
REQ-003 Parameter WORDS, default 4: words per line (power of two).
REQ-004 clk  input  1  CPU clock; all state updates on the rising edge.
REQ-005 rst  input  1  Reset; asynchronous and active-high.
REQ-006 cpu_re  input  1  Memory-stage load request.
REQ-007 cpu_we  input  1  Memory-stage store request.
REQ-008 cpu_addr  input  WIDTH  Byte address; bits [1:0] are ignored (word access only).
REQ-009 cpu_wdata  input  WIDTH  Store data.
REQ-010 cpu_rdata  output  WIDTH  Load data, valid when cpu_re=1 and cpu_stall=0.
REQ-011 cpu_stall  output  1  Pipeline hold request to the hazard logic.
REQ-012 mem_req  output  1  Backing-memory request.
REQ-013 mem_we  output  1  Backing-memory write (1) or read (0).
REQ-014 mem_addr  output  WIDTH  Word-aligned backing-memory address.
REQ-015 mem_wdata  output  WIDTH  Backing-memory write data.
REQ-016 mem_ready  input  1  Beat accepted/completed this cycle.
REQ-017 mem_rdata  input  WIDTH  Read beat data, valid with mem_ready.

Function
REQ-018 Organisation SHALL be direct-mapped, write-through, no-write-allocate; default split: offset = addr[3:2], index = addr[6:4], tag = addr[31:7]; each line holds a valid bit, a tag and WORDS data words.
REQ-019 Hit SHALL be valid[index] AND tag match, evaluated combinationally in IDLE.
REQ-020 FSM states SHALL be IDLE, REFILL and WRITE.
REQ-021 IDLE with cpu_re=1, cpu_we=0 and a hit: cpu_rdata = line word[offset] in the same cycle, cpu_stall=0, state unchanged.
REQ-022 IDLE with cpu_re=1, cpu_we=0 and a miss: cpu_stall=1 in the same cycle; next state REFILL; beat counter cleared to 0; valid[index] cleared.
REQ-023 In REFILL: mem_req=1, mem_we=0, mem_addr = {tag, index, beat, 2'b00}; on each mem_ready, store mem_rdata into word[beat] and increment beat.
REQ-024 On the mem_ready of beat WORDS-1: write the tag, set valid, return to IDLE. The held request then hits and cpu_stall falls that cycle (minimum miss penalty: WORDS+1 cycles).
REQ-025 IDLE with cpu_we=1: cpu_stall=1; next state WRITE; address, data and the hit result are latched.
REQ-026 In WRITE: mem_req=1, mem_we=1, mem_addr = latched word address, mem_wdata = latched data; on mem_ready, if the latched hit was 1, update the cached word; then return to IDLE.
REQ-027 After a write completes, the held store request SHALL NOT be reissued: completion sets a done flag that masks cpu_we for one cycle, so cpu_stall=0 on that cycle.
REQ-028 cpu_re and cpu_we both asserted SHALL be treated as a store; cpu_rdata is don't-care.
REQ-029 cpu_stall SHALL be 1 throughout REFILL and WRITE; the CPU holds its request stable while stalled.
REQ-030 No request in IDLE: mem_req=0, cpu_stall=0, cpu_rdata=0.
REQ-031 The beat counter SHALL wrap from WORDS-1 to 0; mem_ready=0 cycles insert wait states with no state change.
REQ-032 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-033 rst=1 SHALL immediately clear all valid bits, force state IDLE, clear the beat counter and done flag, and drive cpu_stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0.
REQ-034 Reset during REFILL or WRITE SHALL abort the transaction; the partially filled line remains invalid.
REQ-035 Data and tag arrays need not be reset.

Verification
REQ-036 Cold load 0x100, memory returns 0xA0..0xA3 with mem_ready=1 every cycle -> stall for 5 cycles, mem_addr sequence 0x100, 0x104, 0x108, 0x10C, cpu_rdata=0xA0.
REQ-037 Load 0x108 after REQ-036 -> hit, cpu_stall=0, cpu_rdata=0xA2, mem_req=0.
REQ-038 Store 0xDEADBEEF to 0x104 (hit), then load 0x104 -> one write beat at 0x104; load returns 0xDEADBEEF with no refill.
REQ-039 Store to 0x900 (miss), then load 0x900 -> write beat with no allocation; the load then refills from 0x900.
REQ-040 Load 0x180 (same index as 0x100, different tag) with mem_ready gaps of 2 cycles -> refill evicts the old line and stall lasts 13 cycles; a following load of 0x100 misses.
REQ-041 rst asserted after beat 2 of a refill, then the same load reissued -> all outputs 0 immediately; a full 4-beat refill occurs again.
